jelly3_stream_arbiter: RTL and testbench
========================================

# jelly3_stream_arbiter

Round-robin arbiter that merges `NUM` valid/ready input streams onto one registered output stream. It shares a single downstream consumer, such as a skid buffer, FIFO or DMA write port, between several requesters. Each output beat is tagged with the index of its source. Packets can optionally be held together: once a packet starts, the grant stays on that input until its last beat.

## Interface
Parameters
- `NUM`, default 4: number of input streams, 1..64.
- `ID_BITS`, default `NUM > 1 ? $clog2(NUM) : 1`: width of the source index.
- `id_t`, default `logic [ID_BITS-1:0]`: source index type.
- `DATA_BITS`, default 8: payload width.
- `data_t`, default `logic [DATA_BITS-1:0]`: payload type.

Ports
- `reset`  in  1  synchronous, active-high reset.
- `clk`  in  1  clock.
- `cke`  in  1  clock enable; when low, all state holds.
- `s_data`  in  `data_t [NUM]`  input payloads.
- `s_last`  in  `[NUM]`  end-of-packet flags.
- `s_valid`  in  `[NUM]`  input valid.
- `s_ready`  out  `[NUM]`  input ready; combinational from `m_ready`.
- `m_data`  out  `data_t`  output payload.
- `m_last`  out  1  output end-of-packet flag.
- `m_id`  out  `id_t`  source index of the current output beat.
- `m_valid`  out  1  output valid.
- `m_ready`  in  1  output ready.
- `locked`  out  1  a packet is in progress (always 0 without the macro).

## Operation
- Output register slot: `out_ready = !m_valid || m_ready`.
- Arbitration runs only when `out_ready && cke`.
- Round-robin search:
  - Candidate = first `i` with `s_valid[i]`, searching indices `rr_ptr, rr_ptr+1, ..., NUM-1, 0, ..., rr_ptr-1`.
  - Grant is one-hot.
  - With no valid input there is no grant and all `s_ready` are 0.
- `s_ready[i] = out_ready && grant[i]`. It is never asserted for a non-granted input, even if that input is valid.
- Beat accepted from `i`:
  - `m_data <= s_data[i]`, `m_last <= s_last[i]`, `m_id <= i`, `m_valid <= 1`.
  - `rr_ptr <= (i+1)` mod `NUM`. Wrap from `NUM-1` to 0; `NUM` need not be a power of two.
- `out_ready` high with no beat accepted: `m_valid <= 0`.
- `out_ready` low: output registers and `rr_ptr` hold.
- Lock state machine (macro only), two states:
  - IDLE → LOCK on an accepted beat with `s_last=0`; record `lock_id <= i`.
  - LOCK → IDLE on an accepted beat from `lock_id` with `s_last=1`.
  - In LOCK, grant is forced to `lock_id` whatever the other valids are. If `s_valid[lock_id]=0`, no input is accepted (bubble); other inputs stay stalled.
  - `rr_ptr` advances only on the beat that ends a packet.
- `NUM=1`:
  - Grant is tied to input 0, `m_id=0`, `rr_ptr` is constant 0.
  - Throughput is still 1 beat/cycle.

## Timing
- Latency: input accept to `m_valid` is 1 cycle.
- Throughput: 1 beat/cycle sustained when `m_ready=1`.
- Back-to-back switching between inputs costs no idle cycle.
- Reset values:
  - `m_valid=0`, `m_last=0`, `m_id=0`, `m_data=0`.
  - `locked=0`, `rr_ptr=0`.
  - `s_ready` follows as 0 for all inputs except the granted valid input, since `out_ready=1` after reset.
- Output stability:
  - While `m_valid && !m_ready`, `m_data`/`m_last`/`m_id` are stable.
  - Any upstream valid that is not accepted must hold; this is the standard AXI-stream rule.
- Reset mid-packet: the lock is dropped and `rr_ptr` returns to 0. The partial packet downstream is not terminated; the consumer must also be reset.
- `s_ready` has a combinational path from `m_ready` and all `s_valid`. A registered input stage, if needed, is placed outside this block.

## Configuration
- Macro: `JELLY3_STREAM_ARBITER_PACKET_LOCK_EN`.
- Defined: lock state machine and `lock_id` register are present. Packets from different inputs never interleave on the output.
- Undefined:
  - Every beat is arbitrated independently; `s_last` is passed through to `m_last` unused by the arbiter.
  - `locked` is tied to 0.
  - Beats of different packets may interleave, and downstream separates them using `m_id`.

## Test plan
- Reset then all `s_valid=0`, `m_ready=1` → `m_valid=0` every cycle; all `s_ready=0`.
- `NUM=4`, all inputs valid with single-beat packets (`s_last=1`), `m_ready=1` → `m_id` sequence 0,1,2,3,0,… with no gaps.
- Lock on: input 2 sends 3-beat packet A0..A2 while input 0 is continuously valid → `m_data` A0,A1,A2, then input 0's beat. `locked=1` on the cycles after A0 and A1 are accepted.
- Lock on: input 1 packet with `s_valid[1]` dropped for 2 cycles mid-packet while input 3 is valid → `s_ready[3]` stays 0 and `m_valid=0` for 2 cycles; the packet then completes.
- `m_ready=0` for 5 cycles holding beat id=1 data 0x5A → `m_*` are stable and all `s_ready=0`. The first cycle after `m_ready=1`, the next grant is id=2.
- Assert `reset` while `locked=1` → the next cycle `locked=0` and `m_valid=0`. The first grant after reset is the lowest-index valid input.

Source files
------------

// File: rtl/jelly3_stream_arbiter.sv
// Round-robin merge of NUM valid/ready streams onto one registered output, each beat tagged with its source id.
// Define JELLY3_STREAM_ARBITER_PACKET_LOCK_EN to hold the grant on one input from its first beat until s_last.
//
// Lock state machine (only present with JELLY3_STREAM_ARBITER_PACKET_LOCK_EN):
//   state   | meaning
//   ST_IDLE | no packet open; every beat is arbitrated round-robin
//   ST_LOCK | packet from lock_id in progress; grant pinned to lock_id
module jelly3_stream_arbiter #(
  parameter int  NUM       = 4,
  parameter int  ID_BITS   = NUM > 1 ? $clog2(NUM) : 1,
  parameter type id_t      = logic [ID_BITS-1:0],
  parameter int  DATA_BITS = 8,
  parameter type data_t    = logic [DATA_BITS-1:0]
) (
  input  logic               reset,
  input  logic               clk,
  input  logic               cke,

  input  data_t  [NUM-1:0]   s_data,
  input  logic   [NUM-1:0]   s_last,
  input  logic   [NUM-1:0]   s_valid,
  output logic   [NUM-1:0]   s_ready,

  output data_t              m_data,
  output logic               m_last,
  output id_t                m_id,
  output logic               m_valid,
  input  logic               m_ready,

  output logic               locked
);

  logic out_ready;
  id_t  rr_ptr;
  logic search_valid;
  id_t  search_idx;
  logic grant_valid;
  id_t  grant_idx;
  logic accept;
  logic rr_advance;
  id_t  next_ptr;

  assign out_ready = !m_valid || m_ready;

  function automatic id_t wrap_idx(input id_t base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NUM) begin
      sum = sum - NUM;
    end
    return id_t'(sum);
  endfunction

  // Walk offsets from the far end so the nearest valid input after rr_ptr wins.
  always_comb begin
    search_valid = 1'b0;
    search_idx   = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (s_valid[wrap_idx(rr_ptr, k)]) begin
        search_valid = 1'b1;
        search_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

`ifdef JELLY3_STREAM_ARBITER_PACKET_LOCK_EN
  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } lock_state_t;

  lock_state_t lock_state;
  id_t         lock_id;

  // An open packet pins the grant even when its input bubbles; others stay stalled.
  always_comb begin
    if (lock_state == ST_LOCK) begin
      grant_valid = s_valid[lock_id];
      grant_idx   = lock_id;
    end else begin
      grant_valid = search_valid;
      grant_idx   = search_idx;
    end
  end

  assign rr_advance = s_last[grant_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= ST_IDLE;
      lock_id    <= '0;
      locked     <= 1'b0;
    end else if (accept) begin
      case (lock_state)
        ST_IDLE: begin
          if (!s_last[grant_idx]) begin
            lock_state <= ST_LOCK;
            lock_id    <= grant_idx;
            locked     <= 1'b1;
          end
        end
        ST_LOCK: begin
          if (s_last[grant_idx]) begin
            lock_state <= ST_IDLE;
            locked     <= 1'b0;
          end
        end
        default: begin
          lock_state <= ST_IDLE;
          locked     <= 1'b0;
        end
      endcase
    end
  end
`else
  assign grant_valid = search_valid;
  assign grant_idx   = search_idx;
  assign rr_advance  = 1'b1;
  assign locked      = 1'b0;
`endif

  assign accept   = cke && out_ready && grant_valid;
  assign next_ptr = (grant_idx == id_t'(NUM - 1)) ? '0 : grant_idx + id_t'(1);

  always_comb begin
    s_ready = '0;
    if (accept) begin
      s_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
      m_valid <= 1'b0;
      rr_ptr  <= '0;
    end else if (cke && out_ready) begin
      if (grant_valid) begin
        m_data  <= s_data[grant_idx];
        m_last  <= s_last[grant_idx];
        m_id    <= grant_idx;
        m_valid <= 1'b1;
        if (rr_advance) begin
          rr_ptr <= next_ptr;
        end
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jelly3_stream_arbiter.sv
// Scoreboard bench for jelly3_stream_arbiter: a small arbitration model predicts each granted beat.
module tb_jelly3_stream_arbiter;
  localparam int NUM = 4;
`ifdef JELLY3_STREAM_ARBITER_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cke;
  logic [NUM-1:0][7:0]  s_data;
  logic [NUM-1:0]       s_last;
  logic [NUM-1:0]       s_valid;
  logic [NUM-1:0]       s_ready;
  logic [7:0]           m_data;
  logic                 m_last;
  logic [1:0]           m_id;
  logic                 m_valid;
  logic                 m_ready;
  logic                 locked;

  always #5 clk = ~clk;

  jelly3_stream_arbiter #(
    .NUM       (NUM),
    .DATA_BITS (8)
  ) dut (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_id    (m_id),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .locked  (locked)
  );

  typedef struct packed {
    logic       bub;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] id;
  } exp_t;

  beat_t      in_q [NUM][$];
  exp_t       exp_q[$];
  logic [7:0] acc_data[$];
  int         acc_id[$];

  int checks = 0;
  int errors = 0;

  int mdl_rr      = 0;
  bit mdl_lock    = 1'b0;
  int mdl_lock_id = 0;
  bit mdl_mvalid  = 1'b0;

  task automatic push_beat(input int i, input logic [7:0] d, input logic l);
    beat_t b;
    b.bub = 1'b0; b.data = d; b.last = l;
    in_q[i].push_back(b);
  endtask

  task automatic push_bub(input int i);
    beat_t b;
    b.bub = 1'b1; b.data = '0; b.last = 1'b0;
    in_q[i].push_back(b);
  endtask

  task automatic clear_logs();
    acc_data.delete();
    acc_id.delete();
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() > 0);
    for (int i = 0; i < NUM; i++) if (in_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock: drive queue heads, check DUT against the model at negedge, advance the model.
  task automatic cycle();
    logic [NUM-1:0] acc;
    logic [NUM-1:0] exp_sr;
    logic           orr;
    int             g;
    exp_t           e;
    for (int i = 0; i < NUM; i++) begin
      if (in_q[i].size() > 0 && !in_q[i][0].bub) begin
        s_valid[i] = 1'b1; s_data[i] = in_q[i][0].data; s_last[i] = in_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0; s_data[i] = '0; s_last[i] = 1'b0;
      end
    end
    @(negedge clk);
    acc = '0;
    if (!reset) begin
      orr = !mdl_mvalid || m_ready;
      g = -1;
      if (LOCK_EN && mdl_lock) begin
        if (s_valid[mdl_lock_id]) g = mdl_lock_id;
      end else begin
        for (int k = 0; k < NUM; k++)
          if (g < 0 && s_valid[(mdl_rr + k) % NUM]) g = (mdl_rr + k) % NUM;
      end
      exp_sr = '0;
      if (orr && g >= 0) exp_sr[g] = 1'b1;
      checks++;
      if (s_ready !== exp_sr) begin
        errors++; $display("FAIL s_ready: got %b expected %b at %0t", s_ready, exp_sr, $time);
      end
      checks++;
      if (m_valid !== mdl_mvalid) begin
        errors++; $display("FAIL m_valid: got %b expected %b at %0t", m_valid, mdl_mvalid, $time);
      end
      checks++;
      if (locked !== mdl_lock) begin
        errors++; $display("FAIL locked: got %b expected %b at %0t", locked, mdl_lock, $time);
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL out_beat: got unexpected beat id=%0d data=%h, expected none", m_id, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_last, m_id} !== {e.data, e.last, e.id}) begin
            errors++;
            $display("FAIL out_beat: got data=%h last=%b id=%0d expected data=%h last=%b id=%0d",
                     m_data, m_last, m_id, e.data, e.last, e.id);
          end
          acc_data.push_back(m_data);
          acc_id.push_back(int'(m_id));
        end
      end
      if (orr) begin
        if (g >= 0) begin
          e.data = s_data[g]; e.last = s_last[g]; e.id = 2'(g);
          exp_q.push_back(e);
          mdl_mvalid = 1'b1;
          if (!LOCK_EN) begin
            mdl_rr = (g + 1) % NUM;
          end else if (s_last[g]) begin
            mdl_lock = 1'b0;
            mdl_rr   = (g + 1) % NUM;
          end else if (!mdl_lock) begin
            mdl_lock    = 1'b1;
            mdl_lock_id = g;
          end
        end else begin
          mdl_mvalid = 1'b0;
        end
      end
      acc = s_valid & s_ready;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      mdl_rr = 0; mdl_lock = 1'b0; mdl_lock_id = 0; mdl_mvalid = 1'b0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < NUM; i++)
        if (in_q[i].size() > 0 && (in_q[i][0].bub || acc[i])) void'(in_q[i].pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (pending()) begin
      errors++; $display("FAIL drain: got %0d cycles without finishing, expected at most %0d", n, budget);
      exp_q.delete();
      for (int i = 0; i < NUM; i++) in_q[i].delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cke = 1'b1; m_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({m_valid, m_last, m_id, m_data, locked} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: got valid=%b last=%b id=%0d data=%h locked=%b expected all 0",
               m_valid, m_last, m_id, m_data, locked);
    end
    reset = 1'b0;
    repeat (4) begin
      cycle();
      checks++;
      if (s_ready !== 4'b0000 || m_valid !== 1'b0) begin
        errors++; $display("FAIL idle: got s_ready=%b m_valid=%b expected 0000/0", s_ready, m_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    clear_logs();
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < NUM; i++) push_beat(i, 8'((i << 4) | n), 1'b1);
    repeat (13) cycle();
    checks++;
    if (acc_id.size() != 12) begin
      errors++; $display("FAIL rr_no_gaps: got %0d beats in 13 cycles expected 12", acc_id.size());
    end
    for (int j = 0; j < acc_id.size(); j++) begin
      checks++;
      if (acc_id[j] != j % NUM) begin
        errors++; $display("FAIL rr_order: beat %0d got id %0d expected %0d", j, acc_id[j], j % NUM);
      end
    end
    drain(50);
  endtask

  task automatic test_packet_lock();
    logic [7:0] want [5];
    int lk;
`ifdef JELLY3_STREAM_ARBITER_PACKET_LOCK_EN
    want = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1};
`else
    want = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2};
`endif
    clear_logs();
    push_bub(0); push_beat(0, 8'hB0, 1'b1); push_beat(0, 8'hB1, 1'b1);
    push_beat(2, 8'hA0, 1'b0); push_beat(2, 8'hA1, 1'b0); push_beat(2, 8'hA2, 1'b1);
    lk = 0;
    repeat (8) begin
      cycle();
      if (locked === 1'b1) lk++;
    end
    checks++;
    if (lk != (LOCK_EN ? 2 : 0)) begin
      errors++; $display("FAIL lock_cycles: got %0d expected %0d", lk, LOCK_EN ? 2 : 0);
    end
    checks++;
    if (acc_data.size() != 5) begin
      errors++; $display("FAIL lock_count: got %0d beats expected 5", acc_data.size());
    end
    for (int j = 0; j < 5 && j < acc_data.size(); j++) begin
      checks++;
      if (acc_data[j] !== want[j]) begin
        errors++; $display("FAIL lock_order: beat %0d got %h expected %h", j, acc_data[j], want[j]);
      end
    end
    drain(50);
  endtask

  task automatic test_lock_bubble();
    logic [7:0] want [5];
    int idle;
`ifdef JELLY3_STREAM_ARBITER_PACKET_LOCK_EN
    want = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hD1};
`else
    want = '{8'hC0, 8'hD0, 8'hD1, 8'hC1, 8'hC2};
`endif
    clear_logs();
    push_beat(1, 8'hC0, 1'b0); push_bub(1); push_bub(1);
    push_beat(1, 8'hC1, 1'b0); push_beat(1, 8'hC2, 1'b1);
    push_bub(3); push_beat(3, 8'hD0, 1'b1); push_beat(3, 8'hD1, 1'b1);
    idle = 0;
    repeat (7) begin
      cycle();
      if (m_valid === 1'b0) idle++;
    end
    checks++;
    if (idle != 2) begin
      errors++; $display("FAIL bubble_idle: got %0d idle cycles expected 2", idle);
    end
    drain(50);
    checks++;
    if (acc_data.size() != 5) begin
      errors++; $display("FAIL bubble_count: got %0d beats expected 5", acc_data.size());
    end
    for (int j = 0; j < 5 && j < acc_data.size(); j++) begin
      checks++;
      if (acc_data[j] !== want[j]) begin
        errors++; $display("FAIL bubble_order: beat %0d got %h expected %h", j, acc_data[j], want[j]);
      end
    end
  endtask

  task automatic test_stall();
    clear_logs();
    m_ready = 1'b1;
    push_beat(1, 8'h5A, 1'b1);
    push_bub(0); push_beat(0, 8'hE0, 1'b1);
    push_bub(2); push_beat(2, 8'hF0, 1'b1);
    push_bub(3); push_beat(3, 8'h70, 1'b1);
    cycle();
    checks++;
    if ({m_valid, m_id, m_data} !== {1'b1, 2'd1, 8'h5A}) begin
      errors++; $display("FAIL stall_load: got valid=%b id=%0d data=%h expected 1/1/5a", m_valid, m_id, m_data);
    end
    m_ready = 1'b0;
    repeat (5) begin
      cycle();
      checks++;
      if ({m_valid, m_last, m_id, m_data} !== {1'b1, 1'b1, 2'd1, 8'h5A} || s_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b last=%b id=%0d data=%h s_ready=%b expected 1/1/1/5a/0000",
                 m_valid, m_last, m_id, m_data, s_ready);
      end
    end
    m_ready = 1'b1;
    cycle();
    checks++;
    if ({m_valid, m_id, m_data} !== {1'b1, 2'd2, 8'hF0}) begin
      errors++; $display("FAIL stall_next: got valid=%b id=%0d data=%h expected 1/2/f0", m_valid, m_id, m_data);
    end
    drain(50);
  endtask

  task automatic test_reset_locked();
    clear_logs();
    m_ready = 1'b1;
    push_beat(0, 8'h90, 1'b0); push_beat(0, 8'h91, 1'b0); push_beat(0, 8'h92, 1'b1);
    cycle();
    checks++;
    if (locked !== LOCK_EN) begin
      errors++; $display("FAIL reset_pre_lock: got locked=%b expected %b", locked, LOCK_EN);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (locked !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_drop: got locked=%b m_valid=%b expected 0/0", locked, m_valid);
    end
    for (int i = 0; i < NUM; i++) in_q[i].delete();
    push_beat(1, 8'h61, 1'b1);
    push_beat(3, 8'h63, 1'b1);
    cycle();
    checks++;
    if ({m_valid, m_id, m_data} !== {1'b1, 2'd1, 8'h61}) begin
      errors++; $display("FAIL reset_first_grant: got valid=%b id=%0d data=%h expected 1/1/61", m_valid, m_id, m_data);
    end
    drain(50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = '0; s_data = '0; s_last = '0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_lock_bubble();
    test_stall();
    test_reset_locked();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
